// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, registers the fetched word for decode,
// and applies delayed-branch redirects, stalls and halt-on-jump-to-zero.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        active,
  output logic        addr_error
);

  typedef enum logic [1:0] {RUN, PENDING, HALTED} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] target_reg, target_next;
  logic [31:0] out_reg, out_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic        valid_reg, valid_next;
  logic        active_reg, active_next;
  logic        error_reg, error_next;

  logic [31:0] aligned_target;
  logic        misaligned;
  logic [31:0] fetch_next;

  assign aligned_target = {branch_target[31:2], 2'b00};
  assign misaligned     = |branch_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_VECTOR;
      target_reg <= '0;
      out_reg    <= '0;
      out_pc_reg <= '0;
      valid_reg  <= 1'b0;
      active_reg <= 1'b1;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      out_reg    <= out_next;
      out_pc_reg <= out_pc_next;
      valid_reg  <= valid_next;
      active_reg <= active_next;
      error_reg  <= error_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    out_next    = out_reg;
    out_pc_next = out_pc_reg;
    valid_next  = valid_reg;
    active_next = active_reg;
    error_next  = error_reg;
    fetch_next  = pc_reg + 32'd4;

    case (state_reg)
      HALTED: begin
        valid_next = 1'b0;
      end
      default: begin
        if (stall) begin
          // A redirect seen during a stall is parked until the pipeline moves again;
          // a second redirect while one is parked belongs to a delay slot and is dropped.
          if (state_reg == RUN && branch_taken) begin
            state_next  = PENDING;
            target_next = aligned_target;
            error_next  = error_reg | misaligned;
          end
        end else begin
          out_next    = instr_readdata;
          out_pc_next = pc_reg;
          valid_next  = 1'b1;
          if (state_reg == PENDING) begin
            fetch_next = target_reg;
            state_next = RUN;
          end else if (branch_taken) begin
            fetch_next = aligned_target;
            error_next = error_reg | misaligned;
          end
          pc_next = fetch_next;
          if (fetch_next == HALT_ADDR) begin
            state_next  = HALTED;
            active_next = 1'b0;
          end
        end
      end
    endcase
  end

  assign instr_address = pc_reg;
  assign instr_out     = out_reg;
  assign instr_pc      = out_pc_reg;
  assign instr_valid   = valid_reg;
  assign active        = active_reg;
  assign addr_error    = error_reg;

endmodule
